// File: rtl/bit_scan_pkg.sv
// Shared types and constants for the bit-scan coprocessor.
package bit_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int MODE_VAL = 0;
    localparam int MODE_DIR = 1;
    localparam int MODE_CNT = 2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/bit_scan_unit_enc.sv
// Combinational chunk encoder: hit flag, lowest set offset and popcount of one chunk.
module bsu_chunk_enc #(
    parameter int CHUNK = 4,
    parameter int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1,
    parameter int CNT_W = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] chunk_i,
    output logic             hit_o,
    output logic [OFF_W-1:0] off_o,
    output logic [CNT_W-1:0] pop_o
);

    assign hit_o = |chunk_i;

    // Walking downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        off_o = '0;
        pop_o = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (chunk_i[i]) begin
                off_o = OFF_W'(i);
            end
            pop_o = pop_o + CNT_W'(chunk_i[i]);
        end
    end

endmodule

// File: rtl/bit_scan_unit.sv
// Multi-cycle bit-scan unit: finds lowest/highest bit of a chosen value, or counts them,
// examining CHUNK bits per clock behind a start/done handshake.
module bit_scan_unit
    import bit_scan_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int IDX_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IDX_W-1:0] index,
    output logic [IDX_W-1:0] count
);

    localparam int NCH   = nchunk(WIDTH, CHUNK);
    localparam int CUR_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;
    localparam int CNT_W = $clog2(CHUNK) + 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
        $error("bit_scan_unit: WIDTH must be a positive multiple of CHUNK");
    end

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       mode_q;
    logic [CUR_W-1:0] cursor_q;
    logic [IDX_W-1:0] acc_q;
    logic             busy_q;
    logic             done_q;
    logic             found_q;
    logic [IDX_W-1:0] index_q;
    logic [IDX_W-1:0] count_q;

    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] work_d;
    logic [WIDTH-1:0] shifted;
    logic [CHUNK-1:0] chunk;
    logic             hit;
    logic [OFF_W-1:0] off;
    logic [CNT_W-1:0] pop;
    logic [IDX_W-1:0] acc_d;
    logic [IDX_W-1:0] pos;
    logic [IDX_W-1:0] hit_idx;
    logic [CUR_W-1:0] cursor_d;
    logic             last;

    // The scan always runs upward from bit 0, so highest-first becomes a bit reversal at load.
    always_comb begin
        target = mode[MODE_VAL] ? operand : ~operand;
        work_d = target;
        if (mode[MODE_DIR]) begin
            for (int i = 0; i < WIDTH; i++) begin
                work_d[i] = target[WIDTH-1-i];
            end
        end
    end

    assign shifted = work_q >> (int'(cursor_q) * CHUNK);
    assign chunk   = shifted[CHUNK-1:0];

    bsu_chunk_enc #(
        .CHUNK(CHUNK),
        .OFF_W(OFF_W),
        .CNT_W(CNT_W)
    ) u_enc (
        .chunk_i(chunk),
        .hit_o  (hit),
        .off_o  (off),
        .pop_o  (pop)
    );

    assign acc_d    = acc_q + IDX_W'(pop);
    assign pos      = IDX_W'(int'(cursor_q) * CHUNK) + IDX_W'(off);
    assign hit_idx  = mode_q[MODE_DIR] ? (IDX_W'(WIDTH - 1) - pos) : pos;
    assign cursor_d = cursor_q + CUR_W'(1);
    assign last     = (cursor_q == CUR_W'(NCH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            mode_q   <= '0;
            cursor_q <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            index_q  <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        work_q   <= work_d;
                        mode_q   <= mode;
                        cursor_q <= '0;
                        acc_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                SCAN: begin
                    if (!mode_q[MODE_CNT] && hit) begin
                        found_q <= 1'b1;
                        index_q <= hit_idx;
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (last) begin
                        if (mode_q[MODE_CNT]) begin
                            found_q <= (acc_d != '0);
                            index_q <= '0;
                            count_q <= acc_d;
                        end else begin
                            found_q <= 1'b0;
                            index_q <= IDX_W'(WIDTH);
                            count_q <= '0;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cursor_q <= cursor_d;
                        acc_q    <= acc_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign found = found_q;
    assign index = index_q;
    assign count = count_q;

endmodule

// File: tb/tb_bit_scan_unit.sv
// Bench for bit_scan_unit: three instances (CHUNK 1, 4, 32) against a cycle-level reference model.
module tb_bit_scan_unit;

    localparam int W = 32;
    localparam int IW = 6;

    typedef struct {
        bit f;
        int idx;
        int cnt;
        int lat;
    } res_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [2:0]    mode_r = '0;
    logic [W-1:0]  op_r = '0;
    logic          start [3];
    logic          busy  [3];
    logic          done  [3];
    logic          found [3];
    logic [IW-1:0] index [3];
    logic [IW-1:0] count [3];

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    int   m_rem   [3] = '{0, 0, 0};
    bit   m_done  [3] = '{0, 0, 0};
    bit   m_found [3] = '{0, 0, 0};
    int   m_index [3] = '{0, 0, 0};
    int   m_count [3] = '{0, 0, 0};
    res_t p_res   [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        bit_scan_unit #(
            .WIDTH(W),
            .CHUNK((g == 0) ? 1 : ((g == 1) ? 4 : 32)),
            .IDX_W(IW)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .start  (start[g]),
            .mode   (mode_r),
            .operand(op_r),
            .busy   (busy[g]),
            .done   (done[g]),
            .found  (found[g]),
            .index  (index[g]),
            .count  (count[g])
        );
    end

    function automatic int chunk_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 32);
    endfunction

    // Result and latency straight from the scan rules, walking bits in search order.
    function automatic res_t ref_result(input logic [2:0] md, input logic [W-1:0] op, input int ch);
        res_t r;
        logic [W-1:0] t;
        int hitpos;
        int b;
        t = md[0] ? op : ~op;
        r = '{f: 1'b0, idx: 0, cnt: 0, lat: W / ch};
        if (md[2]) begin
            r.cnt = $countones(t);
            r.f = (r.cnt != 0);
        end else begin
            r.idx = W;
            hitpos = -1;
            for (int s = 0; s < W; s++) begin
                b = md[1] ? (W - 1 - s) : s;
                if (t[b] && hitpos < 0) hitpos = s;
            end
            if (hitpos >= 0) begin
                r.f = 1'b1;
                r.idx = md[1] ? (W - 1 - hitpos) : hitpos;
                r.lat = hitpos / ch + 1;
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_rem[k]   <= 0;
                m_done[k]  <= 1'b0;
                m_found[k] <= 1'b0;
                m_index[k] <= 0;
                m_count[k] <= 0;
            end else if (m_rem[k] > 0) begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 1) begin
                    m_done[k]  <= 1'b1;
                    m_found[k] <= p_res[k].f;
                    m_index[k] <= p_res[k].idx;
                    m_count[k] <= p_res[k].cnt;
                end else begin
                    m_done[k] <= 1'b0;
                end
            end else begin
                m_done[k] <= 1'b0;
                if (start[k]) begin
                    p_res[k] <= ref_result(mode_r, op_r, chunk_of(k));
                    m_rem[k] <= ref_result(mode_r, op_r, chunk_of(k)).lat;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("c%0d_busy", chunk_of(k)), int'(busy[k]), int'(m_rem[k] > 0));
                chk($sformatf("c%0d_done", chunk_of(k)), int'(done[k]), int'(m_done[k]));
                chk($sformatf("c%0d_found", chunk_of(k)), int'(found[k]), int'(m_found[k]));
                chk($sformatf("c%0d_index", chunk_of(k)), int'(index[k]), m_index[k]);
                chk($sformatf("c%0d_count", chunk_of(k)), int'(count[k]), m_count[k]);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((busy[0] || busy[1] || busy[2]) && n < 40) begin
            @(negedge clk);
            n++;
            op_r = $urandom;
            mode_r = 3'($urandom_range(0, 7));
        end
        if (n >= 40) chk("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    // Request on all instances; pin the CHUNK=4 instance to literal results and latency.
    task automatic run_req(input string nm, input logic [2:0] md, input logic [W-1:0] op,
                           input int ef, input int ei, input int ec, input int el);
        int lat;
        bit got;
        @(negedge clk);
        mode_r = md;
        op_r = op;
        for (int k = 0; k < 3; k++) start[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            op_r = $urandom;
            mode_r = 3'($urandom_range(0, 7));
            @(negedge clk);
            lat++;
            if (done[1]) got = 1'b1;
        end
        chk({nm, "_done_seen"}, int'(got), 1);
        chk({nm, "_found"}, int'(found[1]), ef);
        chk({nm, "_index"}, int'(index[1]), ei);
        chk({nm, "_count"}, int'(count[1]), ec);
        chk({nm, "_latency"}, lat, el);
        drain();
    endtask

    initial begin
        int npulse;
        int sel;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy[1]), 0);
        chk("rst_done", int'(done[1]), 0);
        chk("rst_found", int'(found[1]), 0);
        chk("rst_index", int'(index[1]), 0);
        chk("rst_count", int'(count[1]), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        run_req("lz_bb",   3'b000, 32'h0000_00BB, 1, 2, 0, 1);
        run_req("lz_38",   3'b000, 32'h0000_0038, 1, 0, 0, 1);
        run_req("lz_bff",  3'b000, 32'h0000_0BFF, 1, 10, 0, 3);
        run_req("lz_ffff", 3'b000, 32'h0000_FFFF, 1, 16, 0, 5);
        run_req("lz_none", 3'b000, 32'hFFFF_FFFF, 0, 32, 0, 8);
        run_req("cz_ef",   3'b100, 32'h0000_00EF, 1, 0, 25, 8);
        run_req("co_zero", 3'b101, 32'h0000_0000, 0, 0, 0, 8);
        run_req("ho_ef",   3'b011, 32'h0000_00EF, 1, 7, 0, 7);

        // Reset in the middle of a scan.
        @(negedge clk);
        mode_r = 3'b000;
        op_r = 32'h0000_FFFF;
        for (int k = 0; k < 3; k++) start[k] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", int'(busy[1]), 1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy[1]), 0);
        chk("abort_done", int'(done[1]), 0);
        chk("abort_found", int'(found[1]), 0);
        chk("abort_index", int'(index[1]), 0);
        chk("abort_count", int'(count[1]), 0);
        @(negedge clk);
        rst = 1'b0;
        npulse = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done[1]) npulse++;
        end
        chk("abort_no_done", npulse, 0);
        run_req("lz_fresh", 3'b000, 32'h0000_FFFF, 1, 16, 0, 5);

        // Back-to-back on the CHUNK=4 instance with start held through the done cycle.
        @(negedge clk);
        mode_r = 3'b001;
        op_r = 32'h1;
        start[1] = 1'b1;
        npulse = 0;
        @(negedge clk);
        op_r = 32'h2;
        @(negedge clk);
        if (done[1]) npulse++;
        chk("b2b_first_index", int'(index[1]), 0);
        @(negedge clk);
        if (done[1]) npulse++;
        chk("b2b_rebusy", int'(busy[1]), 1);
        start[1] = 1'b0;
        @(negedge clk);
        if (done[1]) npulse++;
        chk("b2b_second_index", int'(index[1]), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done[1]) npulse++;
        end
        chk("b2b_pulses", npulse, 2);

        // Randomized sweep across all three chunk sizes.
        for (int it = 0; it < 80; it++) begin
            @(negedge clk);
            mode_r = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 3);
            case (sel)
                0: op_r = $urandom;
                1: op_r = 32'h1 << $urandom_range(0, 31);
                2: op_r = ~(32'h1 << $urandom_range(0, 31));
                default: op_r = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
            endcase
            for (int k = 0; k < 3; k++) start[k] = 1'b1;
            @(negedge clk);
            op_r = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
            end
            for (int k = 0; k < 3; k++) start[k] = 1'b0;
            drain();
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
